// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, LSB first, one bit per clock.
// Computes D = A - B - Bi (mod 2^WIDTH) and borrow-out Bo over WIDTH SHIFT cycles.
// Optional feature: define SERIAL_SUBTRACTOR_OVERFLOW_EN to add the signed overflow flag V.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bo
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  ,
  output logic             V
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned RES_W = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_last;
  logic               w_d;
  logic               w_br_nxt;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [RES_W-1:0]   r_res;
  logic               r_br;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_d;
  logic               r_bo;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic               r_a_msb;
  logic               r_b_msb;
  logic               r_v;
`endif

  // One-bit full subtractor on the current LSBs and the running borrow
  always_comb begin
    w_d      = r_a[0] ^ r_b[0] ^ r_br;
    w_br_nxt = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    w_last   = (r_state == SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start is only honoured in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Operand/result shift registers, counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_d     <= '0;
      r_bo    <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_v     <= 1'b0;
`endif
    end else begin
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (w_state_nxt == DONE);

      if (w_accept) begin
        r_a     <= A;
        r_b     <= B;
        r_br    <= Bi;
        r_res   <= '0;
        r_cnt   <= '0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        r_a_msb <= A[WIDTH-1];
        r_b_msb <= B[WIDTH-1];
`endif
      end else if (r_state == SHIFT) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_br  <= w_br_nxt;
        r_res <= RES_W'({w_d, r_res} >> 1);
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // The final bit is still combinational on the last edge, so merge it in here
      if (w_last) begin
        r_d  <= {w_d, r_res};
        r_bo <= w_br_nxt;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        r_v  <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign D    = r_d;
  assign Bo   = r_bo;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  assign V    = r_v;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8), randomized against an arithmetic model.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Bi = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         Bo;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic         V;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .A       (A),
    .B       (B),
    .Bi      (Bi),
    .busy    (busy),
    .done    (done),
    .D       (D),
    .Bo      (Bo)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    ,
    .V       (V)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic
  function automatic logic [W-1:0] model_d(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    int diff;
    diff = int'(a) - int'(b) - int'(bi);
    return W'(diff);
  endfunction

  function automatic logic model_bo(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    return (int'(a) < int'(b) + int'(bi));
  endfunction

  function automatic logic model_v(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] d);
    return (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
  endfunction

  // Drive one operation from an IDLE negedge; returns at the negedge after DONE
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input bit poke, input bit b2b,
                        output logic [W-1:0] d, output logic bo, output logic v, output int lat);
    logic [W-1:0] d_hold;
    logic         bo_hold;
    bit           seen;
    d_hold = D;
    bo_hold = Bo;
    seen = 1'b0;
    lat = 0;
    A = a; B = b; Bi = bi; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    while (!seen && lat <= 3 * W) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        n_checks++;
        if (busy !== 1'b1 || D !== d_hold || Bo !== bo_hold)
          $display("FAIL shift_hold: busy=%b D=%h Bo=%b, need busy=1 D=%h Bo=%b", busy, D, Bo, d_hold, bo_hold);
        else
          n_pass++;
        start = poke;
        A = W'($urandom);
        B = W'($urandom);
        Bi = 1'($urandom);
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL done_timeout: no done after %0d cycles, need %0d", lat, W);
    end
    d = D;
    bo = Bo;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    v = V;
`else
    v = 1'b0;
`endif
    start = b2b;
    A = ~a; B = ~b; Bi = ~bi;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || D !== '0 || Bo !== 1'b0)
      $display("FAIL reset_state: busy=%b done=%b D=%h Bo=%b, need 0 0 00 0", busy, done, D, Bo);
    else
      n_pass++;
    start = 1'b1; A = 8'h5A; B = 8'h11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_hold: busy=%b done=%b, need 0 0", busy, done);
    else
      n_pass++;
    start = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [W-1:0] ta [5] = '{8'h05, 8'h03, 8'h00, 8'hFF, 8'hFF};
    logic [W-1:0] tb [5] = '{8'h03, 8'h05, 8'h00, 8'hFF, 8'h00};
    logic         tbi[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] td [5] = '{8'h02, 8'hFE, 8'hFF, 8'hFF, 8'hFF};
    logic         tbo[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] d;
    logic         bo, v;
    int           lat;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], tbi[i], 1'b0, 1'b0, d, bo, v, lat);
      n_checks++;
      if (d !== td[i] || bo !== tbo[i])
        $display("FAIL directed_%0d: D=%h Bo=%b, need D=%h Bo=%b", i, d, bo, td[i], tbo[i]);
      else
        n_pass++;
      n_checks++;
      if (lat !== int'(W))
        $display("FAIL latency_%0d: %0d, need %0d", i, lat, W);
      else
        n_pass++;
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, d;
    logic         bi, bo, v;
    int           lat;
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      bi = 1'($urandom);
      run_op(a, b, bi, 1'($urandom), 1'b0, d, bo, v, lat);
      n_checks++;
      if (d !== model_d(a, b, bi) || bo !== model_bo(a, b, bi) || lat !== int'(W))
        $display("FAIL random_%0d: %h-%h-%b got D=%h Bo=%b lat=%0d, need D=%h Bo=%b lat=%0d",
                 i, a, b, bi, d, bo, lat, model_d(a, b, bi), model_bo(a, b, bi), W);
      else
        n_pass++;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      n_checks++;
      if (v !== model_v(a, b, model_d(a, b, bi)))
        $display("FAIL random_v_%0d: V=%b, need %b", i, v, model_v(a, b, model_d(a, b, bi)));
      else
        n_pass++;
`endif
      // start pokes during SHIFT must not have queued anything
      n_checks++;
      if (busy !== 1'b0)
        $display("FAIL no_queue_%0d: busy=%b, need 0", i, busy);
      else
        n_pass++;
    end
  endtask

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  task automatic test_overflow;
    logic [W-1:0] d;
    logic         bo, v;
    int           lat;
    run_op(8'h80, 8'h01, 1'b0, 1'b0, 1'b0, d, bo, v, lat);
    n_checks++;
    if (d !== 8'h7F || bo !== 1'b0 || v !== 1'b1)
      $display("FAIL ovf_80_01: D=%h Bo=%b V=%b, need 7f 0 1", d, bo, v);
    else
      n_pass++;
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, d, bo, v, lat);
    n_checks++;
    if (d !== 8'h7E || v !== 1'b0)
      $display("FAIL ovf_7f_01: D=%h V=%b, need 7e 0", d, v);
    else
      n_pass++;
  endtask
`endif

  task automatic test_back_to_back;
    logic [W-1:0] d;
    logic         bo, v;
    int           lat;
    run_op(8'h40, 8'h22, 1'b1, 1'b0, 1'b1, d, bo, v, lat);
    n_checks++;
    if (d !== model_d(8'h40, 8'h22, 1'b1) || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL b2b_ignore: D=%h busy=%b done=%b, need D=%h busy=0 done=0",
               d, busy, done, model_d(8'h40, 8'h22, 1'b1));
    else
      n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0)
      $display("FAIL b2b_no_queue: busy=%b, need 0", busy);
    else
      n_pass++;
    run_op(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, d, bo, v, lat);
    n_checks++;
    if (d !== 8'hFF || bo !== 1'b1 || lat !== int'(W))
      $display("FAIL b2b_next: D=%h Bo=%b lat=%0d, need ff 1 %0d", d, bo, lat, W);
    else
      n_pass++;
  endtask

  task automatic test_start_held;
    int cyc;
    int last;
    int ndone;
    A = 8'h10; B = 8'h01; Bi = 1'b0; start = 1'b1;
    cyc = 0; last = -1; ndone = 0;
    while (ndone < 3 && cyc < 100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) begin
        n_checks++;
        if (D !== 8'h0F || Bo !== 1'b0)
          $display("FAIL held_result_%0d: D=%h Bo=%b, need 0f 0", ndone, D, Bo);
        else
          n_pass++;
        if (last >= 0) begin
          n_checks++;
          if (cyc - last !== 10)
            $display("FAIL held_period_%0d: %0d cycles, need 10", ndone, cyc - last);
          else
            n_pass++;
        end
        last = cyc;
        ndone++;
        A = 8'h10; B = 8'h01; Bi = 1'b0;
      end else if (busy) begin
        A = W'($urandom); B = W'($urandom); Bi = 1'($urandom);
      end else begin
        A = 8'h10; B = 8'h01; Bi = 1'b0;
      end
    end
    n_checks++;
    if (ndone !== 3)
      $display("FAIL held_count: %0d results, need 3", ndone);
    else
      n_pass++;
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] d;
    logic         bo, v;
    int           lat;
    bit           saw_done;
    run_op(8'h3C, 8'h11, 1'b0, 1'b0, 1'b0, d, bo, v, lat);
    A = 8'hC3; B = 8'h42; Bi = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || D !== 8'h00 || Bo !== 1'b0)
      $display("FAIL mid_reset: busy=%b done=%b D=%h Bo=%b, need 0 0 00 0", busy, done, D, Bo);
    else
      n_pass++;
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    reset_n = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done)
      $display("FAIL mid_reset_abort: activity after abort, need none");
    else
      n_pass++;
    reset_n = 1'b0;
    #1;
    @(negedge clk);
    reset_n = 1'b1;
    run_op(8'hAA, 8'h55, 1'b0, 1'b0, 1'b0, d, bo, v, lat);
    n_checks++;
    if (d !== 8'h55 || bo !== 1'b0 || lat !== int'(W))
      $display("FAIL post_reset_op: D=%h Bo=%b lat=%0d, need 55 0 %0d", d, bo, lat, W);
    else
      n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    test_overflow();
`endif
    test_back_to_back();
    test_start_held();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port start  input  1  request to begin a subtraction, sampled on the rising clk edge.
REQ-005 The block SHALL have port A  input  WIDTH  minuend, sampled only when start is accepted.
REQ-006 The block SHALL have port B  input  WIDTH  subtrahend, sampled only when start is accepted.
REQ-007 The block SHALL have port Bi  input  1  borrow-in, sampled only when start is accepted.
REQ-008 The block SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 The block SHALL have port done  output  1  single-cycle completion pulse.
REQ-010 The block SHALL have port D  output  WIDTH  difference, computed as A - B - Bi modulo 2^WIDTH.
REQ-011 The block SHALL have port Bo  output  1  borrow-out, set when A < B + Bi (unsigned).

Function
REQ-012 The block SHALL implement a three-state FSM with states IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, the block SHALL at the clk edge latch A and B into internal shift registers, load the borrow flop with Bi, clear the bit counter, and enter SHIFT.
REQ-014 In SHIFT, each cycle the block SHALL process one bit, LSB first: d = a0^b0^br; br_next = (~a0&b0) | (~(a0^b0)&br); the A/B registers shift right and d enters the result register at the MSB.
REQ-015 After exactly WIDTH SHIFT cycles, the block SHALL enter DONE and, on that same edge, copy the result register to D and the final borrow to Bo.
REQ-016 DONE SHALL last exactly one cycle, with done=1, after which the block SHALL return to IDLE.
REQ-017 Latency: with start accepted at edge 0, done SHALL be high in the cycle following edge WIDTH, and busy SHALL be high from edge 0 through edge WIDTH.
REQ-018 The block SHALL accept start only in IDLE; start asserted in SHIFT or DONE SHALL be ignored, with no effect on the result and no queued request.
REQ-019 D and Bo SHALL hold their last values until the next completion, and SHALL NOT change during SHIFT.
REQ-020 The block SHALL ignore changes on A, B and Bi after acceptance.
REQ-021 Back-to-back operation: start asserted in the cycle done=1 SHALL be ignored; the earliest next acceptance SHALL be the following cycle (in IDLE).

Reset
REQ-022 On reset_n=0, the block SHALL immediately force state=IDLE, busy=0, done=0, D=0, Bo=0, clear all internal registers and, when compiled in, V=0, all independent of clk.
REQ-023 If reset is asserted mid-operation, the block SHALL abort the operation, produce no done pulse for it, and accept a new start on the first edge after reset_n=1.

Configuration
REQ-024 With macro SERIAL_SUBTRACTOR_OVERFLOW_EN defined, the block SHALL add port V  output  1, the signed two's-complement overflow flag, updated together with D and computed as (A[MSB]!=B[MSB]) && (D[MSB]!=A[MSB]) using the latched operands.
REQ-025 Without SERIAL_SUBTRACTOR_OVERFLOW_EN, port V and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-026 A=0x05, B=0x03, Bi=0, start pulse -> done at cycle 9 after acceptance; D=0x02, Bo=0.
REQ-027 A=0x03, B=0x05, Bi=0 -> D=0xFE, Bo=1; A=0x00, B=0x00, Bi=1 -> D=0xFF, Bo=1.
REQ-028 With overflow enabled: A=0x80, B=0x01 -> D=0x7F, Bo=0, V=1; A=0x7F, B=0x01 -> D=0x7E, V=0.
REQ-029 Start held high continuously with A=0x10, B=0x01 -> one result per 10 cycles (D=0x0F each time); operand changes during SHIFT have no effect.
REQ-030 reset_n pulsed low at SHIFT cycle 4 -> busy=0, D=0x00, Bo=0 asynchronously, no done pulse; a new start of 0xAA-0x55 -> D=0x55, Bo=0.
